// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control FSM: fetch/decode/execute with memory-ready stalls and halt.
// Optional CTRL_SINGLE_STEP_EN adds a step input and a PAUSE state after each instruction.
module control_sequencer #(
  parameter int REG_SIZE = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [REG_SIZE-1:0] ir,
  input  logic                mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                gra,
  output logic                grb,
  output logic                grc,
  output logic                r_in,
  output logic                r_out,
  output logic                ba_out,
  output logic                pc_out,
  output logic                pc_in,
  output logic                incpc,
  output logic                mar_in,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                zlo_out,
  output logic                c_out,
  output logic [3:0]          alu_op,
  output logic                read,
  output logic                write,
  output logic                run
);

  localparam logic [3:0] T0    = 4'd0;
  localparam logic [3:0] T1    = 4'd1;
  localparam logic [3:0] T2    = 4'd2;
  localparam logic [3:0] T3    = 4'd3;
  localparam logic [3:0] T4    = 4'd4;
  localparam logic [3:0] T5    = 4'd5;
  localparam logic [3:0] T6    = 4'd6;
  localparam logic [3:0] T7    = 4'd7;
  localparam logic [3:0] HALT  = 4'd8;
  localparam logic [3:0] PAUSE = 4'd9;

`ifdef CTRL_SINGLE_STEP_EN
  localparam logic [3:0] END_STATE = PAUSE;
`else
  localparam logic [3:0] END_STATE = T0;
`endif

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [2:0] CL_NOP  = 3'd0;
  localparam logic [2:0] CL_RR   = 3'd1;
  localparam logic [2:0] CL_ADDI = 3'd2;
  localparam logic [2:0] CL_LDI  = 3'd3;
  localparam logic [2:0] CL_LD   = 3'd4;
  localparam logic [2:0] CL_ST   = 3'd5;
  localparam logic [2:0] CL_JR   = 3'd6;
  localparam logic [2:0] CL_JAL  = 3'd7;

  typedef struct packed {
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic       ba_out;
    logic       pc_out;
    logic       pc_in;
    logic       incpc;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       y_in;
    logic       z_in;
    logic       zlo_out;
    logic       c_out;
    logic       read;
    logic       write;
    logic [3:0] alu_op;
    logic       run;
  } ctl_t;

  function automatic logic [2:0] op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CL_RR;
      OP_ADDI:                       op_class = CL_ADDI;
      OP_LDI:                        op_class = CL_LDI;
      OP_LD:                         op_class = CL_LD;
      OP_ST:                         op_class = CL_ST;
      OP_JR:                         op_class = CL_JR;
      OP_JAL:                        op_class = CL_JAL;
      default:                       op_class = CL_NOP;
    endcase
  endfunction

  function automatic logic [3:0] rr_alu_code(input logic [4:0] op);
    case (op)
      OP_SUB:  rr_alu_code = 4'd1;
      OP_AND:  rr_alu_code = 4'd2;
      OP_OR:   rr_alu_code = 4'd3;
      default: rr_alu_code = 4'd0;
    endcase
  endfunction

  logic [3:0] state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       started_q, started_d;
  logic [2:0] cls_q_s, cls_d_s;
  ctl_t       ctl_q, ctl_d;
  logic       unused_ir_s;

  assign unused_ir_s = ^ir[REG_SIZE-6:0];
  assign cls_q_s     = op_class(op_q);
  assign cls_d_s     = op_class(op_d);

  // Next-state: the first cycle after reset presents T0; memory steps wait for mem_ready.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    started_d = 1'b1;
    if (!started_q) begin
      state_d = T0;
    end else begin
      case (state_q)
        T0: state_d = T1;
        T1: state_d = mem_ready ? T2 : T1;
        T2: begin
          state_d = T3;
          op_d    = ir[REG_SIZE-1 -: 5];
        end
        T3: begin
          case (cls_q_s)
            CL_RR, CL_ADDI, CL_LDI, CL_LD, CL_ST, CL_JAL: state_d = T4;
            CL_JR:   state_d = END_STATE;
            default: state_d = (op_q == OP_HALT) ? HALT : END_STATE;
          endcase
        end
        T4: state_d = (cls_q_s == CL_JAL) ? END_STATE : T5;
        T5: state_d = ((cls_q_s == CL_LD) || (cls_q_s == CL_ST)) ? T6 : END_STATE;
        T6: state_d = ((cls_q_s == CL_LD) && !mem_ready) ? T6 : T7;
        T7: state_d = ((cls_q_s == CL_ST) && !mem_ready) ? T7 : END_STATE;
        HALT: state_d = HALT;
`ifdef CTRL_SINGLE_STEP_EN
        PAUSE: state_d = step ? T0 : PAUSE;
`else
        PAUSE: state_d = T0;
`endif
        default: state_d = T0;
      endcase
    end
  end

  // Strobe decode of the upcoming state, so the registered outputs always match state_q.
  always_comb begin
    ctl_d     = '0;
    ctl_d.run = (state_d != HALT);
    case (state_d)
      T0: begin
        ctl_d.pc_out = 1'b1; ctl_d.mar_in = 1'b1; ctl_d.incpc = 1'b1;
        ctl_d.alu_op = 4'd4; ctl_d.z_in   = 1'b1;
      end
      T1: begin
        ctl_d.zlo_out = 1'b1; ctl_d.pc_in = 1'b1; ctl_d.read = 1'b1; ctl_d.mdr_in = 1'b1;
      end
      T2: begin
        ctl_d.mdr_out = 1'b1; ctl_d.ir_in = 1'b1;
      end
      T3: begin
        case (cls_d_s)
          CL_RR, CL_ADDI: begin
            ctl_d.grb = 1'b1; ctl_d.r_out = 1'b1; ctl_d.y_in = 1'b1;
          end
          CL_LDI, CL_LD, CL_ST: begin
            ctl_d.grb = 1'b1; ctl_d.ba_out = 1'b1; ctl_d.y_in = 1'b1;
          end
          CL_JR: begin
            ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.pc_in = 1'b1;
          end
          // R15 is forced by select_encode, so no register-select strobe here.
          CL_JAL: begin
            ctl_d.pc_out = 1'b1; ctl_d.r_in = 1'b1;
          end
          default: ctl_d.run = 1'b1;
        endcase
      end
      T4: begin
        case (cls_d_s)
          CL_RR: begin
            ctl_d.grc = 1'b1; ctl_d.r_out = 1'b1; ctl_d.z_in = 1'b1;
            ctl_d.alu_op = rr_alu_code(op_d);
          end
          CL_ADDI, CL_LDI, CL_LD, CL_ST: begin
            ctl_d.c_out = 1'b1; ctl_d.z_in = 1'b1; ctl_d.alu_op = 4'd0;
          end
          CL_JAL: begin
            ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.pc_in = 1'b1;
          end
          default: ctl_d.run = 1'b1;
        endcase
      end
      T5: begin
        case (cls_d_s)
          CL_RR, CL_ADDI, CL_LDI: begin
            ctl_d.zlo_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
          end
          CL_LD, CL_ST: begin
            ctl_d.zlo_out = 1'b1; ctl_d.mar_in = 1'b1;
          end
          default: ctl_d.run = 1'b1;
        endcase
      end
      T6: begin
        case (cls_d_s)
          CL_LD: begin
            ctl_d.read = 1'b1; ctl_d.mdr_in = 1'b1;
          end
          CL_ST: begin
            ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; ctl_d.mdr_in = 1'b1;
          end
          default: ctl_d.run = 1'b1;
        endcase
      end
      T7: begin
        case (cls_d_s)
          CL_LD: begin
            ctl_d.mdr_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1;
          end
          CL_ST: ctl_d.write = 1'b1;
          default: ctl_d.run = 1'b1;
        endcase
      end
      default: ctl_d.alu_op = 4'd0;
    endcase
  end

  // State, opcode and strobe registers; reset leaves only run asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= T0;
      op_q      <= 5'd0;
      started_q <= 1'b0;
      ctl_q     <= {23'd0, 1'b1};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      started_q <= started_d;
      ctl_q     <= ctl_d;
    end
  end

  assign gra     = ctl_q.gra;
  assign grb     = ctl_q.grb;
  assign grc     = ctl_q.grc;
  assign r_in    = ctl_q.r_in;
  assign r_out   = ctl_q.r_out;
  assign ba_out  = ctl_q.ba_out;
  assign pc_out  = ctl_q.pc_out;
  assign pc_in   = ctl_q.pc_in;
  assign incpc   = ctl_q.incpc;
  assign mar_in  = ctl_q.mar_in;
  assign mdr_in  = ctl_q.mdr_in;
  assign mdr_out = ctl_q.mdr_out;
  assign ir_in   = ctl_q.ir_in;
  assign y_in    = ctl_q.y_in;
  assign z_in    = ctl_q.z_in;
  assign zlo_out = ctl_q.zlo_out;
  assign c_out   = ctl_q.c_out;
  assign alu_op  = ctl_q.alu_op;
  assign read    = ctl_q.read;
  assign write   = ctl_q.write;
  assign run     = ctl_q.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed vector table, multi-cycle corner sequences,
// and a randomized instruction/mem_ready stream checked against a per-instruction expected trace.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ir;
  logic        mem_ready;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step;
`endif
  logic gra, grb, grc, r_in, r_out, ba_out, pc_out, pc_in, incpc, mar_in;
  logic mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out, read, write, run;
  logic [3:0] alu_op;

  control_sequencer #(.REG_SIZE(32)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .pc_out(pc_out), .pc_in(pc_in), .incpc(incpc), .mar_in(mar_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .zlo_out(zlo_out),
    .c_out(c_out), .alu_op(alu_op), .read(read), .write(write), .run(run)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] RUN     = 24'h000001;
  localparam logic [23:0] ALU_SUB = 24'h000002;
  localparam logic [23:0] ALU_AND = 24'h000004;
  localparam logic [23:0] ALU_OR  = 24'h000006;
  localparam logic [23:0] ALU_INC = 24'h000008;
  localparam logic [23:0] WRITE   = 24'h000020;
  localparam logic [23:0] READ    = 24'h000040;
  localparam logic [23:0] C_OUT   = 24'h000080;
  localparam logic [23:0] ZLO_OUT = 24'h000100;
  localparam logic [23:0] Z_IN    = 24'h000200;
  localparam logic [23:0] Y_IN    = 24'h000400;
  localparam logic [23:0] IR_IN   = 24'h000800;
  localparam logic [23:0] MDR_OUT = 24'h001000;
  localparam logic [23:0] MDR_IN  = 24'h002000;
  localparam logic [23:0] MAR_IN  = 24'h004000;
  localparam logic [23:0] INCPC   = 24'h008000;
  localparam logic [23:0] PC_IN   = 24'h010000;
  localparam logic [23:0] PC_OUT  = 24'h020000;
  localparam logic [23:0] BA_OUT  = 24'h040000;
  localparam logic [23:0] R_OUT   = 24'h080000;
  localparam logic [23:0] R_IN    = 24'h100000;
  localparam logic [23:0] GRC     = 24'h200000;
  localparam logic [23:0] GRB     = 24'h400000;
  localparam logic [23:0] GRA     = 24'h800000;

  localparam logic [23:0] T0W = PC_OUT | MAR_IN | INCPC | ALU_INC | Z_IN | RUN;
  localparam logic [23:0] T1W = ZLO_OUT | PC_IN | READ | MDR_IN | RUN;
  localparam logic [23:0] T2W = MDR_OUT | IR_IN | RUN;
  localparam logic [23:0] RRB = GRB | R_OUT | Y_IN | RUN;
  localparam logic [23:0] EAB = GRB | BA_OUT | Y_IN | RUN;
  localparam logic [23:0] CZ  = C_OUT | Z_IN | RUN;
  localparam logic [23:0] WB  = ZLO_OUT | GRA | R_IN | RUN;

`ifdef CTRL_SINGLE_STEP_EN
  localparam int          EXTRA = 1;
  localparam logic [23:0] AFTER = RUN;
`else
  localparam int          EXTRA = 0;
  localparam logic [23:0] AFTER = T0W;
`endif

  logic [23:0] got_w;
  assign got_w = {gra, grb, grc, r_in, r_out, ba_out, pc_out, pc_in, incpc, mar_in, mdr_in,
                  mdr_out, ir_in, y_in, z_in, zlo_out, c_out, read, write, alu_op, run};

  int checks = 0;
  int failures = 0;
  logic [23:0] tr[64];
  logic [23:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          cycles;
    logic [23:0] w3;
    logic [23:0] w4;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string nm, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    mem_ready = 1'b0;
    ir = 32'd0;
    @(negedge clk);
    check("reset_state", got_w, RUN);
    reset_n = 1'b1;
    mem_ready = 1'b1;
  endtask

  // Records ncyc visible steps; mem_ready is low for stall_len cycles after step stall_at.
  task automatic run_trace(input logic [31:0] ir_v, input int ncyc, input int stall_at,
                           input int stall_len, input int step_at);
    ir = ir_v;
`ifdef CTRL_SINGLE_STEP_EN
    step = (step_at == 0);
`endif
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      tr[c] = got_w;
      mem_ready = !((c >= stall_at) && (c < stall_at + stall_len));
`ifdef CTRL_SINGLE_STEP_EN
      step = (c >= step_at);
`endif
    end
  endtask

  function automatic int first_t0(input int ncyc);
    for (int c = 1; c < ncyc; c++) begin
      if (tr[c] == T0W) return c;
    end
    return -1;
  endfunction

  task automatic push_instr(input logic [4:0] op);
    exp_q.push_back(T0W);
    exp_q.push_back(T1W);
    exp_q.push_back(T2W);
    case (op)
      5'b00011: begin exp_q.push_back(RRB); exp_q.push_back(GRC | R_OUT | Z_IN | RUN); exp_q.push_back(WB); end
      5'b00100: begin exp_q.push_back(RRB); exp_q.push_back(GRC | R_OUT | Z_IN | ALU_SUB | RUN); exp_q.push_back(WB); end
      5'b01010: begin exp_q.push_back(RRB); exp_q.push_back(GRC | R_OUT | Z_IN | ALU_AND | RUN); exp_q.push_back(WB); end
      5'b01011: begin exp_q.push_back(RRB); exp_q.push_back(GRC | R_OUT | Z_IN | ALU_OR | RUN); exp_q.push_back(WB); end
      5'b01100: begin exp_q.push_back(RRB); exp_q.push_back(CZ); exp_q.push_back(WB); end
      5'b00001: begin exp_q.push_back(EAB); exp_q.push_back(CZ); exp_q.push_back(WB); end
      5'b00000: begin
        exp_q.push_back(EAB); exp_q.push_back(CZ); exp_q.push_back(ZLO_OUT | MAR_IN | RUN);
        exp_q.push_back(READ | MDR_IN | RUN); exp_q.push_back(MDR_OUT | GRA | R_IN | RUN);
      end
      5'b00010: begin
        exp_q.push_back(EAB); exp_q.push_back(CZ); exp_q.push_back(ZLO_OUT | MAR_IN | RUN);
        exp_q.push_back(GRA | R_OUT | MDR_IN | RUN); exp_q.push_back(WRITE | RUN);
      end
      5'b10011: exp_q.push_back(GRA | R_OUT | PC_IN | RUN);
      5'b10100: begin exp_q.push_back(PC_OUT | R_IN | RUN); exp_q.push_back(GRA | R_OUT | PC_IN | RUN); end
      default: exp_q.push_back(RUN);
    endcase
    if (EXTRA == 1) exp_q.push_back(RUN);
  endtask

  function automatic logic [4:0] pick_op();
    logic [4:0] ops[10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 5'd11, 5'd12, 5'd19, 5'd20};
    logic [4:0] op;
    int r = $urandom_range(0, 11);
    if (r < 10) return ops[r];
    op = 5'($urandom_range(0, 31));
    if (op == 5'd27) op = 5'd31;
    return op;
  endfunction

  initial begin
    int cnt;
    logic [4:0] op;
    reset_n = 1'b0;
    mem_ready = 1'b0;
    ir = 32'd0;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    vt[0]  = '{"add",  32'h18918000, 6, RRB, GRC | R_OUT | Z_IN | RUN};
    vt[1]  = '{"sub",  32'h20000000, 6, RRB, GRC | R_OUT | Z_IN | ALU_SUB | RUN};
    vt[2]  = '{"and",  32'h50000000, 6, RRB, GRC | R_OUT | Z_IN | ALU_AND | RUN};
    vt[3]  = '{"or",   32'h58000000, 6, RRB, GRC | R_OUT | Z_IN | ALU_OR | RUN};
    vt[4]  = '{"addi", 32'h60000000, 6, RRB, CZ};
    vt[5]  = '{"ldi",  32'h08000000, 6, EAB, CZ};
    vt[6]  = '{"ld",   32'h01080055, 8, EAB, CZ};
    vt[7]  = '{"st",   32'h10000000, 8, EAB, CZ};
    vt[8]  = '{"jr",   32'h98000000, 4, GRA | R_OUT | PC_IN | RUN, AFTER};
    vt[9]  = '{"jal",  32'hA2800000, 5, PC_OUT | R_IN | RUN, GRA | R_OUT | PC_IN | RUN};
    vt[10] = '{"nop",  32'hF8000000, 4, RUN, AFTER};

    for (int i = 0; i < 11; i++) begin
      do_reset();
      run_trace(vt[i].ir, 16, 99, 0, 0);
      check({vt[i].name, "_t0"}, tr[0], T0W);
      check({vt[i].name, "_t1"}, tr[1], T1W);
      check({vt[i].name, "_t3"}, tr[3], vt[i].w3);
      check({vt[i].name, "_t4"}, tr[4], vt[i].w4);
      cnt = first_t0(16);
      check({vt[i].name, "_cycles"}, 24'(cnt), 24'(vt[i].cycles + EXTRA));
    end

    // Asynchronous reset in the middle of an add.
    do_reset();
    run_trace(32'h18918000, 5, 99, 0, 0);
    check("abort_pre_t4", tr[4], GRC | R_OUT | Z_IN | RUN);
    #2 reset_n = 1'b0;
    #1 check("abort_async", got_w, RUN);
    @(negedge clk);
    check("abort_held", got_w, RUN);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_restart_t0", got_w, T0W);

    // Load with mem_ready low for 3 cycles in T6.
    do_reset();
    run_trace(32'h01080055, 16, 6, 3, 0);
    for (int c = 6; c < 10; c++) check("ld_stall_t6", tr[c], READ | MDR_IN | RUN);
    check("ld_stall_t7", tr[10], MDR_OUT | GRA | R_IN | RUN);
    check("ld_stall_cycles", 24'(first_t0(16)), 24'(11 + EXTRA));

    // Fetch stall in T1.
    do_reset();
    run_trace(32'h18918000, 10, 1, 2, 0);
    check("fetch_stall_a", tr[2], T1W);
    check("fetch_stall_b", tr[3], T1W);
    check("fetch_stall_t2", tr[4], T2W);

    // Halt: run drops after T3 and stays down regardless of mem_ready.
    do_reset();
    run_trace(32'hD8000000, 4, 99, 0, 0);
    check("halt_t3", tr[3], RUN);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("halt_hold", got_w, 24'd0);
      mem_ready = ~mem_ready;
    end

`ifdef CTRL_SINGLE_STEP_EN
    // Single-step: addi retires, holds PAUSE while step is low.
    do_reset();
    run_trace(32'h60000000, 18, 99, 0, 15);
    for (int c = 6; c < 16; c++) check("pause_hold", tr[c], RUN);
    check("pause_release", tr[16], T0W);
    step = 1'b1;
`endif

    // Randomized instruction stream with random mem_ready.
    do_reset();
    exp_q.delete();
    op = pick_op();
    ir = {op, 27'($urandom)};
    push_instr(op);
    mem_ready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      check("random_step", got_w, exp_q[0]);
      mem_ready = ($urandom_range(0, 2) != 0);
      if (((exp_q[0] & (READ | WRITE)) == 24'd0) || mem_ready) void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        op = pick_op();
        ir = {op, 27'($urandom)};
        push_instr(op);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
